// File: rtl/rv_operand_fetch_if.sv
// Operand-fetch bus bundle: issue side, writeback,
// register-file ports and the execute-side handshake.
interface rv_operand_fetch_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_rs1;
  logic [4:0]      i_rs2;
  logic [4:0]      i_rd;
  logic            i_rd_we;
  logic            i_wb_valid;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic [4:0]      o_rf_rs1;
  logic [4:0]      o_rf_rs2;
  logic [4:0]      o_rf_rd;
  logic            o_rf_write;
  logic [XLEN-1:0] o_rf_data;
  logic [XLEN-1:0] i_rf_data1;
  logic [XLEN-1:0] i_rf_data2;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_op1;
  logic [XLEN-1:0] o_op2;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic [30:0]     o_sb;
  logic            o_wb_err;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rd, i_rd_we,
    input  i_wb_valid, i_wb_rd, i_wb_data,
    input  i_rf_data1, i_rf_data2, i_ready,
    output o_ready, o_rf_rs1, o_rf_rs2, o_rf_rd,
    output o_rf_write, o_rf_data, o_valid,
    output o_op1, o_op2, o_rd, o_rd_we, o_sb, o_wb_err
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_rd, i_rd_we,
    output i_wb_valid, i_wb_rd, i_wb_data,
    output i_rf_data1, i_rf_data2, i_ready,
    input  o_ready, o_rf_rs1, o_rf_rs2, o_rf_rd,
    input  o_rf_write, o_rf_data, o_valid,
    input  o_op1, o_op2, o_rd, o_rd_we, o_sb, o_wb_err
  );
endinterface

// File: rtl/rv_operand_fetch.sv
// Operand fetch: scoreboard, regfile read alignment, S1/S2 pipe.
// Define RV_OPF_BYPASS_EN for same-cycle writeback bypass.
module rv_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic               i_clk,
  input logic               i_reset_n,
  rv_operand_fetch_if.slave bus
);

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_nxt;
  logic             s1_v;
  logic             s2_v;
  logic [4:0]       s1_rs1;
  logic [4:0]       s1_rs2;
  logic [4:0]       s1_rd;
  logic             s1_we;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op2_q;
  logic [4:0]       rd_q;
  logic             rd_we_q;
  logic             wb_err_q;
  logic [XLEN-1:0]  op1_nxt;
  logic [XLEN-1:0]  op2_nxt;
  logic             haz1;
  logic             haz2;
  logic             waw;
  logic             hazard;
  logic             blocked;
  logic             s2_load;
  logic             acc;
  logic             wb_hit;
  logic             set_rd;
`ifdef RV_OPF_BYPASS_EN
  logic             clr1;
  logic             clr2;
  logic             clrd;
  logic             s1_byp1;
  logic             s1_byp2;
  logic [XLEN-1:0]  s1_bdata;
`endif

  always_comb begin
    wb_hit = bus.i_wb_valid && (bus.i_wb_rd != 5'd0);
`ifdef RV_OPF_BYPASS_EN
    clr1 = bus.i_wb_valid && (bus.i_wb_rd == bus.i_rs1);
    clr2 = bus.i_wb_valid && (bus.i_wb_rd == bus.i_rs2);
    clrd = bus.i_wb_valid && (bus.i_wb_rd == bus.i_rd);
    haz1 = (bus.i_rs1 != 5'd0) && sb[bus.i_rs1] && !clr1;
    haz2 = (bus.i_rs2 != 5'd0) && sb[bus.i_rs2] && !clr2;
    waw  = bus.i_rd_we && (bus.i_rd != 5'd0)
        && sb[bus.i_rd] && !clrd;
`else
    haz1 = (bus.i_rs1 != 5'd0) && sb[bus.i_rs1];
    haz2 = (bus.i_rs2 != 5'd0) && sb[bus.i_rs2];
    waw  = bus.i_rd_we && (bus.i_rd != 5'd0) && sb[bus.i_rd];
`endif
    hazard  = haz1 || haz2 || waw;
    blocked = s1_v && s2_v && !bus.i_ready;
    s2_load = s1_v && (!s2_v || bus.i_ready);
    acc     = bus.i_valid && !blocked && !hazard;
    set_rd  = acc && bus.i_rd_we && (bus.i_rd != 5'd0);
    // set is applied last so it wins over a same-cycle clear
    sb_nxt = sb;
    if (wb_hit) sb_nxt[bus.i_wb_rd] = 1'b0;
    if (set_rd) sb_nxt[bus.i_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_comb begin
    op1_nxt = '0;
    op2_nxt = '0;
`ifdef RV_OPF_BYPASS_EN
    if (s1_rs1 != 5'd0)
      op1_nxt = s1_byp1 ? s1_bdata : bus.i_rf_data1;
    if (s1_rs2 != 5'd0)
      op2_nxt = s1_byp2 ? s1_bdata : bus.i_rf_data2;
`else
    if (s1_rs1 != 5'd0) op1_nxt = bus.i_rf_data1;
    if (s1_rs2 != 5'd0) op2_nxt = bus.i_rf_data2;
`endif
  end

  // re-present S1 indices while stalled so read data stays fresh
  assign bus.o_rf_rs1   = acc ? bus.i_rs1 : s1_rs1;
  assign bus.o_rf_rs2   = acc ? bus.i_rs2 : s1_rs2;
  assign bus.o_rf_rd    = bus.i_wb_rd;
  assign bus.o_rf_data  = bus.i_wb_data;
  assign bus.o_rf_write = wb_hit && i_reset_n;
  assign bus.o_ready    = !blocked && !hazard;
  assign bus.o_valid    = s2_v;
  assign bus.o_op1      = op1_q;
  assign bus.o_op2      = op2_q;
  assign bus.o_rd       = rd_q;
  assign bus.o_rd_we    = rd_we_q;
  assign bus.o_sb       = sb[NREGS-1:1];
  assign bus.o_wb_err   = wb_err_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sb       <= '0;
      wb_err_q <= 1'b0;
      s1_v     <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_rd    <= '0;
      s1_we    <= 1'b0;
      s2_v     <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
`ifdef RV_OPF_BYPASS_EN
      s1_byp1  <= 1'b0;
      s1_byp2  <= 1'b0;
      s1_bdata <= '0;
`endif
    end else begin
      sb       <= sb_nxt;
      wb_err_q <= wb_hit && !sb[bus.i_wb_rd];
      if (acc) begin
        s1_v   <= 1'b1;
        s1_rs1 <= bus.i_rs1;
        s1_rs2 <= bus.i_rs2;
        s1_rd  <= bus.i_rd;
        s1_we  <= bus.i_rd_we;
`ifdef RV_OPF_BYPASS_EN
        s1_byp1  <= (bus.i_rs1 != 5'd0)
                 && sb[bus.i_rs1] && clr1;
        s1_byp2  <= (bus.i_rs2 != 5'd0)
                 && sb[bus.i_rs2] && clr2;
        s1_bdata <= bus.i_wb_data;
`endif
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v    <= 1'b1;
        op1_q   <= op1_nxt;
        op2_q   <= op2_nxt;
        rd_q    <= s1_rd;
        rd_we_q <= s1_we && (s1_rd != 5'd0);
      end else if (bus.i_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rv_operand_fetch.md
Name: rv_operand_fetch

Overview:
- Read-side initiator for the 2R1W synchronous-read register file. Each read returns data one cycle after the address is presented. A write and a read of the same register in the same cycle return the old value.
- Accepts decoded instructions (rs1/rs2/rd), drives the register-file read addresses and aligns the 1-cycle read latency.
- Tracks pending destination writes in a scoreboard, stalls on RAW/WAW hazards and bypasses same-cycle writebacks.
- Forwards writeback traffic to the register-file write port. Delivers operands to execute through a valid/ready output register.

Parameters:
XLEN, 32, operand/data width
NREGS, 32, architectural register count; x0 hardwired zero; index width = 5

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous, active-low reset
i_valid  in  1  decoded instruction valid
o_ready  out  1  instruction accepted when i_valid && o_ready
i_rs1  in  5  source 1 index
i_rs2  in  5  source 2 index
i_rd  in  5  destination index
i_rd_we  in  1  instruction writes rd
i_wb_valid  in  1  writeback valid
i_wb_rd  in  5  writeback destination
i_wb_data  in  XLEN  writeback data
o_rf_rs1  out  5  regfile read address 1
o_rf_rs2  out  5  regfile read address 2
o_rf_rd  out  5  regfile write address
o_rf_write  out  1  regfile write enable
o_rf_data  out  XLEN  regfile write data
i_rf_data1  in  XLEN  regfile read data 1 (1-cycle latency)
i_rf_data2  in  XLEN  regfile read data 2
o_valid  out  1  operands valid to execute
i_ready  in  1  execute accepts
o_op1  out  XLEN  operand 1
o_op2  out  XLEN  operand 2
o_rd  out  5  destination passed through
o_rd_we  out  1  rd write enable passed through (0 when rd==0)
o_sb  out  31  scoreboard bits x1..x31
o_wb_err  out  1  1-cycle pulse: writeback to a register with no scoreboard bit

Behaviour:
- Reset (sync, i_reset_n=0 at posedge) clears:
  - all scoreboard bits, S1 valid and S2 valid (o_valid=0);
  - o_op1, o_op2 and o_rd to 0; o_rd_we and o_wb_err to 0.
  - An instruction in flight is discarded. Writebacks presented during reset are ignored: o_rf_write=0.
- Write port: o_rf_write = i_wb_valid && i_wb_rd!=0 && i_reset_n. o_rf_rd=i_wb_rd and o_rf_data=i_wb_data, combinational.
- Pipeline: S1 = metadata register, S2 = output register. An instruction accepted in cycle N gives o_valid in cycle N+2 when there is no backpressure.
- Read addresses:
  - In the accept cycle: o_rf_rs1/o_rf_rs2 = i_rs1/i_rs2.
  - Otherwise: the S1-held indices, so read data remains valid while S1 is stalled.
- Source hazard for rs (rs!=0), only when scoreboard bit sb[rs]=1:
  - If the same-cycle clear (i_wb_valid && i_wb_rd==rs) is present: no stall, bypass.
  - Otherwise: stall.
- WAW hazard: i_rd_we && rd!=0 && sb[rd]=1, with no same-cycle clear of rd → stall.
- o_ready = !S1valid_blocked && !hazard, where S1valid_blocked = S1 valid && S2 valid && !i_ready.
- Bypass: S1 latches a per-source flag and i_wb_data at accept. On S1→S2 transfer, each op uses the bypass data if its flag is set, else i_rf_dataN. rs==0 forces op=0.
- S2 load: when S1 valid && (!S2 valid || i_ready). S2 holds its values while o_valid && !i_ready.
- Scoreboard update for accepted i_rd_we && rd!=0: set sb[rd]. Writeback: clear sb[i_wb_rd]. If set and clear target the same register in the same cycle, set wins.
- o_wb_err = registered (i_wb_valid && i_wb_rd!=0 && !sb[i_wb_rd]). The write is still performed.
- Writebacks to x0: ignored by the scoreboard and by the write port.
- Throughput: 1 instruction/cycle with no hazards and i_ready=1.

Optional Feature:
- RV_OPF_BYPASS_EN, defined: same-cycle writeback bypass as above.
- Undefined:
  - Any set scoreboard bit on rs1, rs2 or rd stalls, regardless of a same-cycle writeback.
  - Bypass flags and data registers are removed.
  - Operands always come from i_rf_dataN; the regfile is written by then.
  - Adds 1 cycle of hazard latency.

Test Plan:
- Reset, then issue rs1=0,rs2=0,rd=0 → o_valid at N+2; o_op1=o_op2=0; o_rd_we=0; o_sb=0.
- Preload x5=0x1234 via writeback, then issue rs1=5,rs2=5 → o_op1=o_op2=0x1234 at N+2.
- Issue rd=7 we=1, then rs1=7 → o_ready=0 until wb x7. With wb x7=0xCAFE in the same cycle and RV_OPF_BYPASS_EN defined → accepted that cycle, o_op1=0xCAFE. Undefined → accepted the next cycle, o_op1=0xCAFE.
- Hold i_ready=0 with 2 instructions issued → o_ready=0 after S1 fills; S2 stable. Release → both delivered in order, no loss or duplication.
- Writeback x9 with sb[9]=0 → o_wb_err pulses 1 cycle; o_rf_write=1. Writeback x0 → o_rf_write=0.
- Assert reset with sb[3]=1 and S2 valid → o_sb=0 and o_valid=0 next cycle; a subsequent rs1=3 issue does not stall.
